frame_bank_ctrl: RTL and testbench

FRAME_BANK_CTRL -- requirements
Module: frame_bank_ctrl

---
 rtl/frame_pkg.sv | 14 +
 rtl/frame_bank_if.sv | 23 ++
 rtl/frame_pix_counter.sv | 28 ++
 rtl/frame_bank_ctrl.sv | 143 ++++++++++++++
 tb/tb_frame_bank_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/frame_pkg.sv
// Shared defaults and state encoding for the frame bank controller slice.
package frame_pkg;

    localparam int PIX_NUM_DEF = 10000;
    localparam int ADDR_W_DEF  = 14;
    localparam int DATA_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } frame_state_e;

endpackage

// File: rtl/frame_bank_if.sv
// Result stream from the processing datapath and the shared write port into both banks.
interface frame_bank_if import frame_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              proc_valid;
    logic [ADDR_W-1:0] proc_addr;
    logic [DATA_W-1:0] proc_data;
    logic              wr_en_a;
    logic              wr_en_b;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output proc_valid, proc_addr, proc_data,
        input  wr_en_a, wr_en_b, wr_addr, wr_data
    );

    modport slave (
        input  proc_valid, proc_addr, proc_data,
        output wr_en_a, wr_en_b, wr_addr, wr_data
    );
endinterface

// File: rtl/frame_pix_counter.sv
// Clearable pixel counter; tc flags the last pixel of a frame (PIX_NUM-1).
module frame_pix_counter import frame_pkg::*; #(
    parameter int PIX_NUM = PIX_NUM_DEF,
    parameter int CNT_W   = ADDR_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(PIX_NUM - 1);

    logic [CNT_W-1:0] count_r;

    // Count accepted pixels; clear wins over increment, wrap after the last pixel.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            count_r <= (count_r == LAST_C) ? {CNT_W{1'b0}} : count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == LAST_C);
endmodule

// File: rtl/frame_bank_ctrl.sv
// Double-buffered frame bank controller: one processing pass writes the hidden bank,
// then the banks swap at the next vertical-blanking boundary.
module frame_bank_ctrl import frame_pkg::*; #(
    parameter int PIX_NUM = PIX_NUM_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         func_sel,
    input  logic         frame_boundary,
    frame_bank_if.slave  bus,
    output logic         op_start,
    output logic         op_func,
    output logic         disp_bank,
    output logic         busy,
    output logic         swap_pulse,
    output logic [7:0]   frames_done,
    output logic         err_overrun,
    output logic         err_addr
);
    localparam logic [ADDR_W:0] PIX_LIM_C = (ADDR_W+1)'(PIX_NUM);

    frame_state_e      state_r, state_nxt_s;
    logic              launch_s, cnt_clr_s, cnt_inc_s, cnt_tc_s, addr_ok_s;
    logic              wr_fire_s, swap_s, err_addr_set_s, err_ovr_set_s;
    logic              op_start_r, op_func_r, disp_bank_r, busy_r, swap_pulse_r;
    logic              wr_en_a_r, wr_en_b_r, err_overrun_r, err_addr_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic [7:0]        frames_done_r;

    assign addr_ok_s = ({1'b0, bus.proc_addr} < PIX_LIM_C);

    frame_pix_counter #(.PIX_NUM(PIX_NUM), .CNT_W(ADDR_W)) u_pix_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr_s),
        .inc (cnt_inc_s),
        .tc  (cnt_tc_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and per-cycle action decode.
    always_comb begin
        state_nxt_s    = state_r;
        launch_s       = 1'b0;
        cnt_clr_s      = 1'b0;
        cnt_inc_s      = 1'b0;
        wr_fire_s      = 1'b0;
        swap_s         = 1'b0;
        err_addr_set_s = 1'b0;
        err_ovr_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    launch_s    = 1'b1;
                    cnt_clr_s   = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
                err_ovr_set_s = bus.proc_valid;
            end
            ST_RUN: begin
                if (bus.proc_valid) begin
                    cnt_inc_s      = 1'b1;
                    wr_fire_s      = addr_ok_s;
                    err_addr_set_s = ~addr_ok_s;
                    // A boundary coinciding with the last pixel is deliberately not honoured here.
                    state_nxt_s    = cnt_tc_s ? ST_WAIT_SWAP : ST_RUN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_WAIT_SWAP: begin
                if (frame_boundary) begin
                    swap_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_SWAP;
                end
                err_ovr_set_s = bus.proc_valid;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Registered outputs; the write bank is always the one not being displayed.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_start_r    <= 1'b0;
            op_func_r     <= 1'b0;
            wr_en_a_r     <= 1'b0;
            wr_en_b_r     <= 1'b0;
            wr_addr_r     <= {ADDR_W{1'b0}};
            wr_data_r     <= {DATA_W{1'b0}};
            disp_bank_r   <= 1'b0;
            busy_r        <= 1'b0;
            swap_pulse_r  <= 1'b0;
            frames_done_r <= 8'd0;
            err_overrun_r <= 1'b0;
            err_addr_r    <= 1'b0;
        end else begin
            op_start_r    <= launch_s;
            op_func_r     <= launch_s ? func_sel : op_func_r;
            wr_en_a_r     <= wr_fire_s & disp_bank_r;
            wr_en_b_r     <= wr_fire_s & ~disp_bank_r;
            wr_addr_r     <= wr_fire_s ? bus.proc_addr : wr_addr_r;
            wr_data_r     <= wr_fire_s ? bus.proc_data : wr_data_r;
            disp_bank_r   <= disp_bank_r ^ swap_s;
            busy_r        <= (state_nxt_s != ST_IDLE);
            swap_pulse_r  <= swap_s;
            frames_done_r <= swap_s ? frames_done_r + 8'd1 : frames_done_r;
            err_overrun_r <= err_overrun_r | err_ovr_set_s;
            err_addr_r    <= err_addr_r | err_addr_set_s;
        end
    end

    assign op_start    = op_start_r;
    assign op_func     = op_func_r;
    assign bus.wr_en_a = wr_en_a_r;
    assign bus.wr_en_b = wr_en_b_r;
    assign bus.wr_addr = wr_addr_r;
    assign bus.wr_data = wr_data_r;
    assign disp_bank   = disp_bank_r;
    assign busy        = busy_r;
    assign swap_pulse  = swap_pulse_r;
    assign frames_done = frames_done_r;
    assign err_overrun = err_overrun_r;
    assign err_addr    = err_addr_r;
endmodule

// File: tb/tb_frame_bank_ctrl.sv
// Directed bench for frame_bank_ctrl: full passes on both banks, bad address,
// boundary collision, overrun and mid-pass reset.
module tb_frame_bank_ctrl;
    import frame_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, func_sel, frame_boundary;
    logic       op_start, op_func, disp_bank, busy, swap_pulse, err_overrun, err_addr;
    logic [7:0] frames_done;
    logic       exp_disp;
    logic [7:0] exp_frames;
    int         errors = 0;
    int         checks = 0;

    frame_bank_if #(.ADDR_W(14), .DATA_W(8)) bus ();

    frame_bank_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .func_sel       (func_sel),
        .frame_boundary (frame_boundary),
        .bus            (bus),
        .op_start       (op_start),
        .op_func        (op_func),
        .disp_bank      (disp_bank),
        .busy           (busy),
        .swap_pulse     (swap_pulse),
        .frames_done    (frames_done),
        .err_overrun    (err_overrun),
        .err_addr       (err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset;
        chk("rst_op_start", op_start, 32'd0);
        chk("rst_op_func", op_func, 32'd0);
        chk("rst_wr_en_a", bus.wr_en_a, 32'd0);
        chk("rst_wr_en_b", bus.wr_en_b, 32'd0);
        chk("rst_wr_addr", bus.wr_addr, 32'd0);
        chk("rst_wr_data", bus.wr_data, 32'd0);
        chk("rst_disp_bank", disp_bank, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_swap_pulse", swap_pulse, 32'd0);
        chk("rst_frames_done", frames_done, 32'd0);
        chk("rst_err_overrun", err_overrun, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
    endtask

    task automatic do_start(input logic f);
        start = 1'b1;
        func_sel = f;
        tick;
        start = 1'b0;
        func_sel = ~f;
        chk("op_start_pulse", op_start, 32'd1);
        chk("op_func", op_func, {31'd0, f});
        chk("busy_run", busy, 32'd1);
        tick;
        chk("op_start_once", op_start, 32'd0);
        chk("op_func_hold", op_func, {31'd0, f});
    endtask

    // Drive n results with addresses 0..n-1; one index may carry an out-of-range address.
    task automatic feed(input int n, input int bad_idx, input logic bnd_last);
        int         bad;
        logic [7:0] d;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            d = i[7:0] ^ 8'h5A;
            bus.proc_valid = 1'b1;
            bus.proc_addr  = (i == bad_idx) ? 14'd10000 : i[13:0];
            bus.proc_data  = d;
            frame_boundary = bnd_last && (i == n - 1);
            tick;
            if (i == bad_idx) begin
                if (bus.wr_en_a !== 1'b0 || bus.wr_en_b !== 1'b0) bad++;
            end else begin
                if (bus.wr_en_b !== ~exp_disp || bus.wr_en_a !== exp_disp ||
                    bus.wr_addr !== i[13:0] || bus.wr_data !== d) bad++;
            end
            if (op_start !== 1'b0 || swap_pulse !== 1'b0) bad++;
        end
        bus.proc_valid = 1'b0;
        frame_boundary = 1'b0;
        chk("write_stream_bad_cycles", bad, 32'd0);
        tick;
        chk("wr_en_a_after", bus.wr_en_a, 32'd0);
        chk("wr_en_b_after", bus.wr_en_b, 32'd0);
    endtask

    task automatic do_swap;
        frame_boundary = 1'b1;
        tick;
        frame_boundary = 1'b0;
        exp_disp = ~exp_disp;
        exp_frames = exp_frames + 8'd1;
        chk("swap_pulse", swap_pulse, 32'd1);
        chk("disp_bank", disp_bank, {31'd0, exp_disp});
        chk("frames_done", frames_done, {24'd0, exp_frames});
        chk("busy_idle", busy, 32'd0);
        tick;
        chk("swap_pulse_once", swap_pulse, 32'd0);
    endtask

    initial begin
        int ops;
        rst = 1'b1;
        start = 1'b0;
        func_sel = 1'b0;
        frame_boundary = 1'b0;
        bus.proc_valid = 1'b0;
        bus.proc_addr = 14'd0;
        bus.proc_data = 8'd0;
        exp_disp = 1'b0;
        exp_frames = 8'd0;
        tick;
        tick;
        rst = 1'b0;
        check_reset;

        // First pass, median, writes bank B.
        do_start(1'b1);
        feed(10000, -1, 1'b0);
        chk("busy_wait_swap", busy, 32'd1);
        repeat (3) tick;
        chk("no_swap_without_boundary", swap_pulse, 32'd0);
        chk("disp_held_in_wait", disp_bank, {31'd0, exp_disp});
        do_swap;

        // Boundary while idle has no effect.
        frame_boundary = 1'b1;
        tick;
        frame_boundary = 1'b0;
        chk("idle_boundary_no_swap", swap_pulse, 32'd0);
        chk("idle_boundary_frames", frames_done, {24'd0, exp_frames});
        chk("idle_boundary_disp", disp_bank, {31'd0, exp_disp});

        // Second pass, sobel, writes bank A.
        do_start(1'b0);
        feed(10000, -1, 1'b0);
        do_swap;

        // Out-of-range address still counts toward the frame.
        chk("err_addr_clear", err_addr, 32'd0);
        do_start(1'b1);
        feed(10000, 500, 1'b0);
        chk("err_addr_set", err_addr, 32'd1);
        chk("bad_addr_pass_done", busy, 32'd1);
        do_swap;
        chk("err_addr_sticky", err_addr, 32'd1);
        chk("no_overrun_yet", err_overrun, 32'd0);

        // Last valid coincides with boundary: swap must wait for the next one.
        do_start(1'b0);
        feed(10000, -1, 1'b1);
        chk("collide_disp_held", disp_bank, {31'd0, exp_disp});
        chk("collide_still_busy", busy, 32'd1);
        do_swap;

        // Result strobe while idle is an overrun, not a write.
        bus.proc_valid = 1'b1;
        bus.proc_addr = 14'd3;
        tick;
        bus.proc_valid = 1'b0;
        chk("overrun_no_wr_a", bus.wr_en_a, 32'd0);
        chk("overrun_no_wr_b", bus.wr_en_b, 32'd0);
        chk("err_overrun_set", err_overrun, 32'd1);

        // Start while running is ignored.
        do_start(1'b1);
        ops = 0;
        start = 1'b1;
        func_sel = 1'b0;
        repeat (3) begin
            tick;
            if (op_start !== 1'b0) ops++;
        end
        start = 1'b0;
        chk("restart_no_op_start", ops, 32'd0);
        chk("restart_op_func_kept", op_func, 32'd1);

        // Reset mid-pass, then a fresh pass must count from zero.
        feed(5000, -1, 1'b0);
        chk("err_overrun_sticky", err_overrun, 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_reset;
        exp_disp = 1'b0;
        exp_frames = 8'd0;
        do_start(1'b0);
        feed(10000, -1, 1'b0);
        chk("post_reset_no_overrun", err_overrun, 32'd0);
        chk("post_reset_wait_swap", busy, 32'd1);
        do_swap;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
